// File: rtl/phys_free_list.sv
// Circular free list of physical register tags for the rename stage.
// Speculative allocations are undone on flush by restoring the committed head.
module phys_free_list #(
    parameter int unsigned NUM_PHYS = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned TAG_W    = 6
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         stall,
    input  logic                                         flush,
    input  logic                                         alloc_req,
    output logic [TAG_W-1:0]                             alloc_tag,
    output logic                                         alloc_ok,
    input  logic                                         retire_valid,
    input  logic [TAG_W-1:0]                             retire_old_tag,
    output logic [$clog2(NUM_PHYS-NUM_ARCH+1)-1:0]       free_count
);

    localparam int unsigned DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] r_ring [DEPTH];
    logic [PTR_W-1:0] r_spec_head;
    logic [PTR_W-1:0] r_commit_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_alloc;
    logic             w_retire;
    logic [PTR_W-1:0] w_spec_head_nxt;
    logic [PTR_W-1:0] w_commit_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    assign alloc_tag  = r_ring[r_spec_head[IDX_W-1:0]];
    assign alloc_ok   = (r_count != '0);
    assign free_count = r_count;

    // Flush folds in a same-cycle retire before rewinding the speculative head.
    always_comb begin
        w_alloc           = alloc_req && alloc_ok && !stall && !flush;
        w_retire          = retire_valid && !stall;
        w_commit_head_nxt = r_commit_head;
        w_tail_nxt        = r_tail;
        w_spec_head_nxt   = r_spec_head;
        w_count_nxt       = r_count;
        if (w_retire) begin
            w_commit_head_nxt = r_commit_head + PTR_W'(1);
            w_tail_nxt        = r_tail + PTR_W'(1);
        end
        if (flush) begin
            w_spec_head_nxt = w_commit_head_nxt;
            w_count_nxt     = CNT_W'(DEPTH);
        end else begin
            if (w_alloc) begin
                w_spec_head_nxt = r_spec_head + PTR_W'(1);
            end
            if (w_retire && !w_alloc) begin
                w_count_nxt = r_count + CNT_W'(1);
            end else if (w_alloc && !w_retire) begin
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_spec_head   <= '0;
            r_commit_head <= '0;
            r_tail        <= '0;
            r_count       <= CNT_W'(DEPTH);
        end else begin
            r_spec_head   <= w_spec_head_nxt;
            r_commit_head <= w_commit_head_nxt;
            r_tail        <= w_tail_nxt;
            r_count       <= w_count_nxt;
        end
    end

    // Ring reloads with the non-architectural tags; retired old mappings land at tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ring[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else if (w_retire) begin
            r_ring[r_tail[IDX_W-1:0]] <= retire_old_tag;
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        r_count <= CNT_W'(DEPTH));
    a_tail_tracks_commit: assert property (@(posedge clk) disable iff (!reset)
        r_tail[IDX_W-1:0] == r_commit_head[IDX_W-1:0]);
    a_retire_legal: assert property (@(posedge clk) disable iff (!reset)
        w_retire |-> (r_spec_head != r_commit_head));

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: fill/drain, wrap-around, flush recovery, stall.
module tb_phys_free_list;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       flush;
    logic       alloc_req;
    logic [5:0] alloc_tag;
    logic       alloc_ok;
    logic       retire_valid;
    logic [5:0] retire_old_tag;
    logic [5:0] free_count;

    int checks   = 0;
    int failures = 0;

    phys_free_list dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .alloc_req      (alloc_req),
        .alloc_tag      (alloc_tag),
        .alloc_ok       (alloc_ok),
        .retire_valid   (retire_valid),
        .retire_old_tag (retire_old_tag),
        .free_count     (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, sample 1ns later.
    task automatic cyc(input logic a, input logic r, input logic [5:0] old,
                       input logic s, input logic f);
        alloc_req      = a;
        retire_valid   = r;
        retire_old_tag = old;
        stall          = s;
        flush          = f;
        #1;
        if (r && !s) begin
            assert (old != 6'd0) else $error("retire of tag 0");
            assert (free_count < 6'd32) else $error("retire with nothing uncommitted");
        end
        @(posedge clk);
        #1;
        alloc_req    = 1'b0;
        retire_valid = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        chk({tag, "_rst_tag"}, 32'(alloc_tag), 32);
        chk({tag, "_rst_ok"}, 32'(alloc_ok), 1);
        chk({tag, "_rst_cnt"}, 32'(free_count), 32);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        alloc_req = 1'b0; retire_valid = 1'b0; retire_old_tag = '0;
        @(posedge clk);
        #1;
        do_reset("t1");
        cyc(0, 0, 0, 0, 0);
        chk("t1_idle_tag", 32'(alloc_tag), 32);
        chk("t1_idle_cnt", 32'(free_count), 32);

        // Drain the whole list in order, then one more request is ignored.
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t2_tag%0d", i), 32'(alloc_tag), 32'(32 + i));
            cyc(1, 0, 0, 0, 0);
        end
        chk("t2_empty_cnt", 32'(free_count), 0);
        chk("t2_empty_ok", 32'(alloc_ok), 0);
        cyc(1, 0, 0, 0, 0);
        chk("t2_ignored_cnt", 32'(free_count), 0);
        chk("t2_ignored_tag", 32'(alloc_tag), 32);
        chk("t2_ignored_ok", 32'(alloc_ok), 0);

        // Reset mid-operation discards every allocation.
        do_reset("t3");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        chk("t3_after3_cnt", 32'(free_count), 29);
        chk("t3_after3_tag", 32'(alloc_tag), 35);
        cyc(0, 1, 6'd5, 0, 0);
        chk("t3_retire_cnt", 32'(free_count), 30);
        for (int i = 0; i < 29; i++) begin
            chk($sformatf("t3_tag%0d", 35 + i), 32'(alloc_tag), 32'(35 + i));
            cyc(1, 0, 0, 0, 0);
        end
        chk("t3_wrap_tag", 32'(alloc_tag), 5);
        chk("t3_wrap_cnt", 32'(free_count), 1);

        // Flush with a same-cycle retire rewinds to the new committed head.
        do_reset("t4");
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        chk("t4_pre_cnt", 32'(free_count), 28);
        cyc(1, 1, 6'd7, 0, 1);
        chk("t4_flush_cnt", 32'(free_count), 32);
        chk("t4_flush_tag", 32'(alloc_tag), 33);
        for (int i = 0; i < 31; i++) cyc(1, 0, 0, 0, 0);
        chk("t4_wrap_tag", 32'(alloc_tag), 7);
        chk("t4_wrap_cnt", 32'(free_count), 1);

        // Steady alloc+retire: count holds, returned tags reappear after the wrap.
        do_reset("t5");
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("t5_tag%0d", i), 32'(alloc_tag), (i < 31) ? 32'(33 + i) : 32'(i - 30));
            cyc(1, 1, 6'(i + 1), 0, 0);
            chk($sformatf("t5_cnt%0d", i), 32'(free_count), 31);
        end

        // Stall freezes alloc and retire; flush still recovers under stall.
        do_reset("t6");
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t6_pre_tag", 32'(alloc_tag), 34);
        cyc(1, 1, 6'd9, 1, 0);
        chk("t6_stall_cnt", 32'(free_count), 30);
        chk("t6_stall_tag", 32'(alloc_tag), 34);
        cyc(1, 1, 6'd9, 1, 1);
        chk("t6_flush_cnt", 32'(free_count), 32);
        chk("t6_flush_tag", 32'(alloc_tag), 32);
        chk("t6_flush_ok", 32'(alloc_ok), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
